// File: rtl/wb_arbiter.sv
// Register-file write port arbiter: pipeline writeback vs. buffered
// long-latency results, with busy scoreboard and stale-result kill.
module wb_arbiter #(
  parameter int DEPTH = 2,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          pipe_wr,
  input  logic [4:0]    pipe_addr,
  input  logic [DW-1:0] pipe_data,
  input  logic          iss_valid,
  input  logic [4:0]    iss_addr,
  input  logic          aux_valid,
  input  logic [4:0]    aux_addr,
  input  logic [DW-1:0] aux_data,
  output logic          aux_ready,
  output logic          rf_wr,
  output logic [4:0]    rf_addr,
  output logic [DW-1:0] rf_data,
  output logic [31:0]   busy
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [4:0]    fa_q [DEPTH];
  logic [DW-1:0] fd_q [DEPTH];
  logic [AW-1:0] wp_q, wp_d;
  logic [AW-1:0] rp_q, rp_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic          rf_wr_q, rf_wr_d;
  logic [4:0]    rf_addr_q, rf_addr_d;
  logic [DW-1:0] rf_data_q, rf_data_d;
  logic [31:0]   busy_q, busy_d;
  logic [31:0]   kill_q, kill_d;

  logic          pw, push, pop;
  logic [4:0]    ha;
  logic [DW-1:0] hd;
  logic [31:0]   set_m, clr_m, kset_m;

  assign aux_ready = (cnt_q < CW'(DEPTH));

  always_comb begin
    pw   = pipe_wr && (pipe_addr != 5'd0);
    push = aux_valid && aux_ready;
    pop  = !pw && (cnt_q != '0);
    ha   = fa_q[rp_q];
    hd   = fd_q[rp_q];

    set_m  = '0;
    clr_m  = '0;
    kset_m = '0;
    if (iss_valid && (iss_addr != 5'd0))
      set_m = 32'd1 << iss_addr;
    if (pop && (ha != 5'd0))
      clr_m = 32'd1 << ha;
    // A pipe write over an outstanding result makes that result stale
    if (pw && busy_q[pipe_addr])
      kset_m = 32'd1 << pipe_addr;

    busy_d    = (busy_q & ~clr_m) | set_m;
    busy_d[0] = 1'b0;
    kill_d    = (kill_q & ~clr_m) | kset_m;

    rf_wr_d   = 1'b0;
    rf_addr_d = rf_addr_q;
    rf_data_d = rf_data_q;
    if (pw) begin
      rf_wr_d   = 1'b1;
      rf_addr_d = pipe_addr;
      rf_data_d = pipe_data;
    end else if (pop && (ha != 5'd0) && !kill_q[ha]) begin
      rf_wr_d   = 1'b1;
      rf_addr_d = ha;
      rf_data_d = hd;
    end

    wp_d  = push ? wp_q + AW'(1) : wp_q;
    rp_d  = pop  ? rp_q + AW'(1) : rp_q;
    cnt_d = cnt_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wp_q      <= '0;
      rp_q      <= '0;
      cnt_q     <= '0;
      rf_wr_q   <= 1'b0;
      rf_addr_q <= '0;
      rf_data_q <= '0;
      busy_q    <= '0;
      kill_q    <= '0;
    end else begin
      wp_q      <= wp_d;
      rp_q      <= rp_d;
      cnt_q     <= cnt_d;
      rf_wr_q   <= rf_wr_d;
      rf_addr_q <= rf_addr_d;
      rf_data_q <= rf_data_d;
      busy_q    <= busy_d;
      kill_q    <= kill_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fa_q[wp_q] <= aux_addr;
      fd_q[wp_q] <= aux_data;
    end
  end

  assign rf_wr   = rf_wr_q;
  assign rf_addr = rf_addr_q;
  assign rf_data = rf_data_q;
  assign busy    = busy_q;

endmodule
